rr_arbiter_q: RTL and testbench

Parametrised round-robin arbiter for four-phase (return-to-zero) req/ack handshakes, with a per-grant burst quota and optional grant lock. It multiplexes PORTS client handshakes onto one downstream req/ack pair inside the router's output path, one handshake at a time. It replaces the fixed-search arbiter with a fair rotating pointer.

---
 rtl/rr_arbiter_q.sv | 193 +++++++++++++++++++
 tb/tb_rr_arbiter_q.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_q.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_q
// Brief   : Round-robin arbiter that multiplexes PORTS four-phase (RTZ)
//           req/ack client handshakes onto one downstream req/ack pair.
//           Each grant owns the downstream link until its handshake has
//           returned to zero. A burst quota lets a port win up to QUOTA
//           consecutive handshakes before the pointer rotates past it.
//           Optional grant lock: define ARB_LOCK_EN to add the locks_in
//           port. A completing handshake with its lock bit set then pins
//           arbitration to that port.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_q #(
  parameter int ID         = 0,  // router identifier, debug naming only
  parameter int SUBID      = 0,  // instance identifier, debug naming only
  parameter int PORTS      = 5,  // number of clients, 2..255
  parameter int PORT_BITS  = 3,  // 2**PORT_BITS >= PORTS
  parameter int QUOTA      = 1,  // consecutive wins per port, 1..255
  parameter int QUOTA_BITS = 8   // 2**QUOTA_BITS > QUOTA
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PORTS-1:0]     reqs_in,
  output logic [PORTS-1:0]     acks_in,
  output logic                 req_out,
  input  logic                 ack_out,
  output logic [PORT_BITS-1:0] selected,
  output logic                 active
`ifdef ARB_LOCK_EN
  ,
  input  logic [PORTS-1:0]     locks_in
`endif
);

  // Arbiter state: IDLE searches for a winner, BUSY forwards one handshake.
  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  // Extended-width copies of the sizing parameters, so that pointer and
  // counter arithmetic never overflows before the compare.
  localparam logic [PORT_BITS:0]  c_PORTS = (PORT_BITS+1)'(PORTS);
  localparam logic [QUOTA_BITS:0] c_QUOTA = (QUOTA_BITS+1)'(QUOTA);

  logic [0:0]           r_state;
  logic [PORT_BITS-1:0] r_sel;      // current / last granted port
  logic [PORT_BITS-1:0] r_ptr;      // first port searched in IDLE
  logic [QUOTA_BITS-1:0] r_bcnt;    // completed wins of r_sel in this burst
  logic                 r_req_out;
  logic [PORTS-1:0]     r_acks;
`ifdef ARB_LOCK_EN
  logic                 r_lock;     // arbitration pinned to r_sel
`endif

  logic                 w_found;    // some eligible request exists
  logic [PORT_BITS-1:0] w_win;      // first eligible port from r_ptr
  logic [PORT_BITS:0]   w_scan_idx; // scratch index for the rotating search
  logic                 w_done;     // handshake has returned to zero
  logic [QUOTA_BITS:0]  w_bcnt_inc;
  logic                 w_under_quota;
  logic [PORT_BITS:0]   w_sel_inc;
  logic [PORT_BITS-1:0] w_ptr_adv;  // port after r_sel, wrapping at PORTS
  logic [PORTS-1:0]     w_ack_vec;  // ack_out steered to the owner only

  // Rotating priority search. The scan walks backwards from the farthest
  // candidate so that the nearest requester to r_ptr is the last to write.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_scan_idx = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      w_scan_idx = {1'b0, r_ptr} + (PORT_BITS+1)'(k);
      if (w_scan_idx >= c_PORTS) begin
        w_scan_idx = w_scan_idx - c_PORTS;
      end
      if (reqs_in[w_scan_idx[PORT_BITS-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_scan_idx[PORT_BITS-1:0];
      end
    end
`ifdef ARB_LOCK_EN
    // A held lock hides every other requester.
    if (r_lock) begin
      w_found = reqs_in[r_sel];
      w_win   = r_sel;
    end
`endif
  end

  // Completion detect and the pointer/quota arithmetic used when it fires.
  always_comb begin
    w_done        = (r_state == c_BUSY) && !reqs_in[r_sel] && !ack_out;
    w_bcnt_inc    = {1'b0, r_bcnt} + (QUOTA_BITS+1)'(1);
    w_under_quota = (w_bcnt_inc < c_QUOTA);
    w_sel_inc     = {1'b0, r_sel} + (PORT_BITS+1)'(1);
    w_ptr_adv     = (w_sel_inc >= c_PORTS) ? '0 : w_sel_inc[PORT_BITS-1:0];
  end

  // Downstream acknowledge routed back to the owning client only.
  always_comb begin
    w_ack_vec = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_ack_vec[p] = ack_out && (r_sel == PORT_BITS'(p));
    end
  end

  // Handshake forwarding: grant in IDLE, mirror req/ack in BUSY, release
  // at completion. Reset abandons any in-flight handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= c_IDLE;
      r_sel     <= '0;
      r_req_out <= 1'b0;
      r_acks    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_sel     <= w_win;
            r_req_out <= 1'b1;
            r_state   <= c_BUSY;
          end
        end
        c_BUSY: begin
          if (w_done) begin
            r_req_out <= 1'b0;
            r_acks    <= '0;
            r_state   <= c_IDLE;
          end else begin
            r_req_out <= reqs_in[r_sel];
            r_acks    <= w_ack_vec;
          end
        end
        default: begin
          r_state   <= c_IDLE;
          r_req_out <= 1'b0;
          r_acks    <= '0;
        end
      endcase
    end
  end

  // Fairness state: pointer, burst counter and (optionally) the lock.
  // A grant to a different port starts a fresh burst; each completion
  // either keeps priority on the winner or rotates past it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr  <= '0;
      r_bcnt <= '0;
`ifdef ARB_LOCK_EN
      r_lock <= 1'b0;
`endif
    end else if (r_state == c_IDLE) begin
      if (w_found && (w_win != r_sel)) begin
        r_bcnt <= '0;
      end
    end else if (w_done) begin
`ifdef ARB_LOCK_EN
      if (locks_in[r_sel]) begin
        // Locked completion bypasses the quota entirely.
        r_lock <= 1'b1;
        r_ptr  <= r_sel;
      end else begin
        r_lock <= 1'b0;
        if (w_under_quota) begin
          r_bcnt <= w_bcnt_inc[QUOTA_BITS-1:0];
          r_ptr  <= r_sel;
        end else begin
          r_bcnt <= '0;
          r_ptr  <= w_ptr_adv;
        end
      end
`else
      if (w_under_quota) begin
        r_bcnt <= w_bcnt_inc[QUOTA_BITS-1:0];
        r_ptr  <= r_sel;
      end else begin
        r_bcnt <= '0;
        r_ptr  <= w_ptr_adv;
      end
`endif
    end
  end

  assign acks_in  = r_acks;
  assign req_out  = r_req_out;
  assign selected = r_sel;
  assign active   = (r_state == c_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_q.sv
//------------------------------------------------------------------------------
// Module  : tb_rr_arbiter_q
// Brief   : Self-checking bench for rr_arbiter_q (PORTS=5, QUOTA=3).
//           Directed scenarios plus randomized client/downstream traffic,
//           all compared cycle by cycle against a behavioural model.
//           Lock scenario is built only when ARB_LOCK_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_q;

  localparam int PORTS = 5;
  localparam int QUOTA = 3;
`ifdef ARB_LOCK_EN
  localparam bit c_LOCK = 1'b1;
`else
  localparam bit c_LOCK = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [PORTS-1:0] reqs;
  logic [PORTS-1:0] acks;
  logic             req_out;
  logic             ack_out;
  logic [2:0]       selected;
  logic             active;
  logic [PORTS-1:0] locks;

  rr_arbiter_q #(
    .ID(0), .SUBID(0), .PORTS(PORTS), .PORT_BITS(3), .QUOTA(QUOTA), .QUOTA_BITS(8)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reqs_in  (reqs),
    .acks_in  (acks),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .selected (selected),
    .active   (active)
`ifdef ARB_LOCK_EN
    ,
    .locks_in (locks)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Behavioural model state
  bit m_active, m_req, m_lock;
  int m_sel, m_ptr, m_burst, m_acks;

  // Stimulus agents: pmode 0 manual, 1 shot-counted client, 2 random client
  int pmode[PORTS];
  int pshots[PORTS];
  int rc_state[PORTS];
  int ds_mode;   // 0 manual, 1 zero-delay echo, 2 random delay

  int g_log[$];  // ports observed winning a grant, in order
  bit prev_act;
  int idle_run;
  bit gap_chk_en;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int winner;
    if (!reset_n) begin
      m_active = 0; m_req = 0; m_lock = 0;
      m_sel = 0; m_ptr = 0; m_burst = 0; m_acks = 0;
    end else if (!m_active) begin
      winner = -1;
      if (c_LOCK && m_lock) begin
        if (reqs[m_sel]) winner = m_sel;
      end else begin
        for (int k = 0; k < PORTS; k++) begin
          if (winner < 0 && reqs[(m_ptr + k) % PORTS]) winner = (m_ptr + k) % PORTS;
        end
      end
      if (winner >= 0) begin
        if (winner != m_sel) m_burst = 0;
        m_sel = winner; m_active = 1; m_req = 1;
      end
    end else if (!reqs[m_sel] && !ack_out) begin
      m_active = 0; m_req = 0; m_acks = 0;
      if (c_LOCK && locks[m_sel]) begin
        m_lock = 1; m_ptr = m_sel;
      end else begin
        m_lock = 0;
        m_burst = m_burst + 1;
        if (m_burst < QUOTA) m_ptr = m_sel;
        else begin
          m_burst = 0;
          m_ptr = (m_sel + 1) % PORTS;
        end
      end
    end else begin
      m_req  = reqs[m_sel];
      m_acks = ack_out ? (1 << m_sel) : 0;
    end
  endtask

  task automatic drive_next();
    for (int j = 0; j < PORTS; j++) begin
      case (pmode[j])
        1: begin
          if (pshots[j] > 0) begin
            if (acks[j]) begin
              if (reqs[j]) pshots[j]--;
              reqs[j] = 1'b0;
            end else reqs[j] = 1'b1;
          end else reqs[j] = 1'b0;
        end
        2: begin
          case (rc_state[j])
            0: if ($urandom_range(0, 2) == 0) begin reqs[j] = 1'b1; rc_state[j] = 1; end
            1: begin
              if (acks[j]) begin
                if ($urandom_range(0, 1) == 0) begin reqs[j] = 1'b0; rc_state[j] = 2; end
              end else if ($urandom_range(0, 49) == 0) begin
                reqs[j] = 1'b0; rc_state[j] = 2;
              end
            end
            default: if (!acks[j]) rc_state[j] = 0;
          endcase
        end
        default: ;
      endcase
    end
    case (ds_mode)
      1: ack_out = req_out;
      2: begin
        if (req_out && !ack_out && $urandom_range(0, 1) == 0) ack_out = 1'b1;
        else if (!req_out && ack_out && $urandom_range(0, 1) == 0) ack_out = 1'b0;
      end
      default: ;
    endcase
  endtask

  // One clock: advance model on the edge, compare 1 ns later, then drive.
  task automatic tick();
    int obs_v, exp_v;
    @(posedge clk);
    model_step();
    #1;
    obs_v = int'({active, req_out, selected, acks});
    exp_v = (int'(m_active) << 9) | (int'(m_req) << 8) | (m_sel << 5) | m_acks;
    check_val("cycle", obs_v, exp_v);
    if (active && !prev_act) begin
      if (gap_chk_en && g_log.size() > 0) check_val("idle_gap", idle_run, 1);
      g_log.push_back(int'(selected));
      idle_run = 0;
    end else if (!active) idle_run++;
    prev_act = active;
    drive_next();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    reqs = '0; ack_out = 1'b0; locks = '0; ds_mode = 0;
    for (int j = 0; j < PORTS; j++) begin pmode[j] = 0; pshots[j] = 0; rc_state[j] = 0; end
    for (int i = 0; i < n; i++) tick();
    reset_n = 1'b1;
    g_log.delete();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int c;
    c = 0;
    while (g_log.size() < n && c < budget) begin tick(); c++; end
    check_val("grant_count", g_log.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (active && c < budget) begin tick(); c++; end
    check_val("reach_idle", int'(active), 0);
  endtask

  task automatic check_seq(input string tag, input int n, input int e[16]);
    for (int i = 0; i < n; i++) begin
      check_val(tag, (i < g_log.size()) ? g_log[i] : -1, e[i]);
    end
  endtask

  initial begin
    int e[16];
    n_vec = 0; n_bad = 0;
    prev_act = 0; idle_run = 0; gap_chk_en = 0;
    reset_n = 1'b0; reqs = '0; ack_out = 1'b0; locks = '0; ds_mode = 0;
    for (int j = 0; j < PORTS; j++) begin pmode[j] = 0; pshots[j] = 0; rc_state[j] = 0; end

    // Reset state
    do_reset(3);
    check_val("reset_state", int'({active, req_out, selected, acks}), 0);

    // Single-port handshake timing on port 2
    reqs = 5'b00100;
    tick();
    check_val("t1_req_out", int'(req_out), 1);
    check_val("t1_active", int'(active), 1);
    check_val("t1_selected", int'(selected), 2);
    check_val("t1_acks", int'(acks), 0);
    tick(); tick();
    ack_out = 1'b1;
    tick();
    check_val("t4_acks", int'(acks), 5'b00100);
    reqs = '0;
    tick();
    check_val("t5_req_out", int'(req_out), 0);
    check_val("t5_active", int'(active), 1);
    ack_out = 1'b0;
    tick();
    check_val("t6_active", int'(active), 0);
    check_val("t6_acks", int'(acks), 0);

    // Quota run on port 3 moves pointer to 4; then ports 0 and 2 contend
    g_log.delete();
    ds_mode = 1;
    pmode[3] = 1; pshots[3] = 3; reqs[3] = 1'b1;
    wait_grants(3, 100);
    wait_idle(50);
    tick(); tick();
    pmode[0] = 1; pshots[0] = 1; reqs[0] = 1'b1;
    pmode[2] = 1; pshots[2] = 1; reqs[2] = 1'b1;
    tick();
    check_val("wrap_active", int'(active), 1);
    check_val("wrap_selected", int'(selected), 0);
    wait_grants(5, 100);
    e = '{3, 3, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("wrap_seq", 5, e);
    wait_idle(50);

    // Quota with ports 1 and 3 re-requesting continuously
    do_reset(2);
    ds_mode = 1;
    pmode[1] = 1; pshots[1] = 1000;
    pmode[3] = 1; pshots[3] = 1000;
    wait_grants(7, 200);
    e = '{1, 1, 1, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("quota_seq", 7, e);

    // All ports saturated: bursts of QUOTA with exactly one idle cycle
    do_reset(2);
    ds_mode = 1;
    for (int j = 0; j < PORTS; j++) begin pmode[j] = 1; pshots[j] = 1000; end
    gap_chk_en = 1;
    wait_grants(16, 400);
    gap_chk_en = 0;
    e = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 0};
    check_seq("rr_seq", 16, e);

    // Reset in mid-handshake while port 2 owns the link with ptr=2
    do_reset(2);
    ds_mode = 1;
    pmode[2] = 1; pshots[2] = 2;
    wait_grants(2, 100);
    reset_n = 1'b0;
    pshots[2] = 0;
    tick();
    check_val("rst_mid_outputs", int'({active, req_out, selected, acks}), 0);
    reset_n = 1'b1;
    pmode[2] = 0;
    reqs = 5'b10010;
    tick();
    check_val("rst_mid_active", int'(active), 1);
    check_val("rst_mid_selected", int'(selected), 1);
    reqs = '0;
    wait_idle(50);

`ifdef ARB_LOCK_EN
    // Port 4 locks through four handshakes, then port 0 gets in
    do_reset(2);
    ds_mode = 1;
    locks[4] = 1'b1;
    pmode[4] = 1; pshots[4] = 4;
    wait_grants(1, 50);
    pmode[0] = 1; pshots[0] = 1000;
    wait_grants(4, 100);
    locks[4] = 1'b0;
    wait_grants(5, 100);
    e = '{4, 4, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("lock_seq", 5, e);
`endif

    // Randomized traffic with occasional resets and lock requests
    do_reset(2);
    ds_mode = 2;
    for (int j = 0; j < PORTS; j++) pmode[j] = 2;
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 249) != 0);
      locks = PORTS'($urandom_range(0, 31) & $urandom_range(0, 31));
      tick();
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
